lc3_mem_ctrl: RTL and testbench
===============================

Name: lc3_mem_ctrl

Overview:
Sequencer and arbiter for the LC-3 MAR/MDR memory datapath. Shares one single-port memory between the instruction-fetch requester and the load/store (data) requester. For each access it loads MAR (and MDR on writes), holds the memory enable for a fixed latency, captures read data into MDR, then returns a one-cycle acknowledge. Sits between the control FSM/datapath and the memory array.

Parameters:
MEM_LATENCY, 2, cycles from mem_en assertion to valid mem_rdata (legal range 1..15; 0 is illegal and is flagged by an elaboration check)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  in  1  system clock; all state updates on rising edge
aclr  in  1  asynchronous active-low reset
fetch_req  in  1  instruction fetch request; held until fetch_ack
fetch_addr  in  ADDR_W  fetch address (PC)
fetch_ack  out  1  one-cycle pulse: fetch complete, fetch_rdata valid
fetch_rdata  out  DATA_W  fetched instruction (MDR contents)
data_req  in  1  load/store request; held until data_ack
data_we  in  1  1 = store, 0 = load; sampled with data_req
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_ack  out  1  one-cycle pulse: load/store complete
data_rdata  out  DATA_W  load result (MDR contents)
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  MAR contents
mem_wdata  out  DATA_W  MDR contents (store data)
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (aclr=0, asynchronous): state=IDLE; MAR, MDR, counter = 0; mem_en, mem_we, fetch_ack, data_ack, busy = 0; round-robin pointer = fetch-preferred. An access in flight is aborted with no ack. Requesters re-request after reset.
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE: if any req is high, grant, latch MAR <= granted addr, latch the write flag, and latch MDR <= data_wdata on a store. Go to ACCESS and load counter = MEM_LATENCY-1.
- Arbitration: a single requester is granted directly. Simultaneous requests alternate by a round-robin pointer. The pointer flips to the other requester after every grant.
- ACCESS: mem_en=1 and mem_we=write flag on every cycle. mem_addr=MAR and mem_wdata=MDR are stable throughout. Counter decrements. At counter==0: on a read, MDR <= mem_rdata; go to DONE.
- DONE: mem_en=0. Assert the granted requester's ack for exactly one cycle, then go to IDLE.
- fetch_rdata and data_rdata both continuously drive MDR. They are valid in the ack cycle and held until the next read capture.
- Latency: req sampled in IDLE at cycle N; ack at cycle N+MEM_LATENCY+1. Back-to-back accesses take MEM_LATENCY+2 cycles each.
- Req, addr, wdata and we changing after the grant are ignored until the next IDLE.
- A req still high in the cycle after its ack is treated as a new request.
- A store leaves MDR = store data. On a store, data_rdata returns that value and is don't-care to users.

Optional Feature:
LC3_MMIO_EN. When defined, the block adds these ports:
- io_en out 1
- io_we out 1
- io_rdata in DATA_W

Accesses with MAR >= 16'hFE00 (KBSR/KBDR/DSR/DDR region) drive io_en/io_we in place of mem_en/mem_we, with identical timing, and MDR captures io_rdata.

When not defined, these ports are absent and all addresses go to memory.

Decomposition:
Shared package lc3_mem_pkg holds:
- state enum (IDLE, ACCESS, DONE)
- requester id constants (REQ_FETCH, REQ_DATA)
- MMIO_BASE = 16'hFE00

Natural sub-module: lc3_rr_arb2, the two-way round-robin arbiter with the pointer register.

Test Plan:
- Reset with fetch_req=1, fetch_addr=16'h3000, mem[3000]=16'h1234, MEM_LATENCY=2 -> fetch_ack pulses 3 cycles after the request is sampled; fetch_rdata=16'h1234.
- Store: data_we=1, data_addr=16'h4000, data_wdata=16'hBEEF -> mem_we high for 2 cycles with mem_addr=4000 and mem_wdata=BEEF; data_ack pulse; a later load of 16'h4000 returns 16'hBEEF.
- fetch_req and data_req both held high continuously -> grants alternate fetch, data, fetch, data; each ack arrives 4 cycles apart.
- aclr asserted during ACCESS of a store to 16'h5000 -> mem_en and mem_we drop immediately (asynchronously); no ack; busy=0; the post-reset request is serviced normally.
- MEM_LATENCY=1 and MEM_LATENCY=7 builds -> ack latency is 2 and 8 cycles respectively; mem_en is high for exactly 1 and 7 cycles respectively.
- LC3_MMIO_EN build: load 16'hFE02 with io_rdata=16'h8000 -> io_en pulses, mem_en stays 0, data_rdata=16'h8000.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 MAR/MDR memory sequencer.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    // Start of the KBSR/KBDR/DSR/DDR device-register page
    localparam logic [15:0] MMIO_BASE = 16'hFE00;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
// A lone request wins outright; on a tie the pointer decides.
module lc3_rr_arb2
    import lc3_mem_pkg::*;
(
    input  logic clk,
    input  logic aclr,
    input  logic fetch_req,
    input  logic data_req,
    input  logic take,
    output logic grant_id,
    output logic any_req
);

    logic ptr_reg;

    always_comb begin
        any_req = fetch_req | data_req;
        if (fetch_req && data_req) begin
            grant_id = ptr_reg;
        end else if (data_req) begin
            grant_id = REQ_DATA;
        end else begin
            grant_id = REQ_FETCH;
        end
    end

    // After each grant the other requester gets priority on the next tie
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            ptr_reg <= REQ_FETCH;
        end else if (take && any_req) begin
            ptr_reg <= ~grant_id;
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory sequencer: arbitrates fetch vs load/store onto one memory port.
// Define LC3_MMIO_EN to route accesses at or above MMIO_BASE to the io_* port instead.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef LC3_MMIO_EN
    output logic              io_en,
    output logic              io_we,
    input  logic [DATA_W-1:0] io_rdata,
`endif
    output logic              busy
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    generate
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("lc3_mem_ctrl: MEM_LATENCY must be within 1..15");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] mar_reg;
    logic [DATA_W-1:0] mdr_reg;
    logic              we_reg;
    logic              owner_reg;
    logic              take;
    logic              grant_id;
    logic              any_req;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] rdata_sel;
    logic              in_access;

    lc3_rr_arb2 u_arb (
        .clk       (clk),
        .aclr      (aclr),
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .take      (take),
        .grant_id  (grant_id),
        .any_req   (any_req)
    );

    assign grant_addr = (grant_id == REQ_DATA) ? data_addr : fetch_addr;
    assign in_access  = (state_reg == ACCESS);

`ifdef LC3_MMIO_EN
    logic io_reg;

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            io_reg <= 1'b0;
        end else if (take) begin
            io_reg <= (grant_addr >= ADDR_W'(MMIO_BASE));
        end
    end

    assign rdata_sel = io_reg ? io_rdata : mem_rdata;
    assign mem_en    = in_access & ~io_reg;
    assign mem_we    = in_access & ~io_reg & we_reg;
    assign io_en     = in_access & io_reg;
    assign io_we     = in_access & io_reg & we_reg;
`else
    assign rdata_sel = mem_rdata;
    assign mem_en    = in_access;
    assign mem_we    = in_access & we_reg;
`endif

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    take       = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_reg == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // MAR/MDR are only loaded at grant; requester inputs are ignored afterwards
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            mar_reg   <= '0;
            mdr_reg   <= '0;
            cnt_reg   <= 4'd0;
            we_reg    <= 1'b0;
            owner_reg <= REQ_FETCH;
        end else begin
            if (take) begin
                owner_reg <= grant_id;
                cnt_reg   <= CNT_INIT;
                mar_reg   <= grant_addr;
                if (grant_id == REQ_DATA) begin
                    we_reg <= data_we;
                    if (data_we) begin
                        mdr_reg <= data_wdata;
                    end
                end else begin
                    we_reg <= 1'b0;
                end
            end else if (in_access) begin
                if (cnt_reg != 4'd0) begin
                    cnt_reg <= cnt_reg - 4'd1;
                end else if (!we_reg) begin
                    mdr_reg <= rdata_sel;
                end
            end
        end
    end

    assign mem_addr    = mar_reg;
    assign mem_wdata   = mdr_reg;
    assign fetch_rdata = mdr_reg;
    assign data_rdata  = mdr_reg;
    assign fetch_ack   = (state_reg == DONE) && (owner_reg == REQ_FETCH);
    assign data_ack    = (state_reg == DONE) && (owner_reg == REQ_DATA);
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: directed reset/store/arbitration/abort steps plus random traffic.
module tb_lc3_mem_ctrl;

    parameter int MEM_LATENCY = 2;
    localparam int L = MEM_LATENCY;

`ifdef LC3_MMIO_EN
    localparam bit MMIO_BUILD = 1'b1;
`else
    localparam bit MMIO_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        aclr;
    logic        fetch_req;
    logic [15:0] fetch_addr;
    logic        fetch_ack;
    logic [15:0] fetch_rdata;
    logic        data_req;
    logic        data_we;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_ack;
    logic [15:0] data_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        io_en_obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lc3_mem_ctrl #(.MEM_LATENCY(MEM_LATENCY), .ADDR_W(16), .DATA_W(16)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_rdata (fetch_rdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_ack    (data_ack),
        .data_rdata  (data_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
`ifdef LC3_MMIO_EN
        .io_en       (io_en),
        .io_we       (io_we),
        .io_rdata    (io_rdata),
`endif
        .busy        (busy)
    );

    // Power-on contents of the memory
    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    // Memory array: read data is valid only in the MEM_LATENCY-th enabled cycle
    logic [15:0] mem_arr [0:65535];
    bit          mem_wr  [0:65535];
    int          en_cnt = 0;
    logic [15:0] rd_word;

    always @(posedge clk) begin
        if (mem_en) begin
            en_cnt <= en_cnt + 1;
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                mem_wr[mem_addr]  <= 1'b1;
            end
        end else begin
            en_cnt <= 0;
        end
    end

    assign rd_word   = mem_wr[mem_addr] ? mem_arr[mem_addr] : init_word(mem_addr);
    assign mem_rdata = (mem_en && en_cnt == L - 1) ? rd_word : ~rd_word;

`ifdef LC3_MMIO_EN
    logic        io_en;
    logic        io_we;
    logic [15:0] io_rdata;
    int          io_cnt = 0;
    always @(posedge clk) io_cnt <= io_en ? io_cnt + 1 : 0;
    assign io_rdata  = (io_en && io_cnt == L - 1) ? 16'h8000 : 16'h0BAD;
    assign io_en_obs = io_en;
`else
    assign io_en_obs = 1'b0;
`endif

    // Reference: expected memory contents from the stores issued so far
    logic [15:0] ref_mem [logic [15:0]];

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete access; inputs change only at negedges, outputs sampled at negedges
    task automatic do_access(input bit is_data, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input string tag);
        int lat, en_n, we_n, io_n, guard;
        bit stable, other_ack, ack;
        bit is_io;
        logic [15:0] exp, rd;
        is_io = MMIO_BUILD && (addr >= 16'hFE00);
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (is_data) begin
            data_req = 1'b1; data_we = we; data_addr = addr; data_wdata = wdata;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        lat = 0; en_n = 0; we_n = 0; io_n = 0; stable = 1'b1; other_ack = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_en) en_n++;
            if (mem_we) we_n++;
            if (io_en_obs) io_n++;
            if ((mem_en || io_en_obs) && (mem_addr !== addr || (we && mem_wdata !== wdata)))
                stable = 1'b0;
            if (is_data ? fetch_ack : data_ack) other_ack = 1'b1;
            if (lat == 1) begin
                // Post-grant changes must not affect the access in flight
                data_addr = ~addr; data_wdata = ~wdata; fetch_addr = ~addr;
                if (is_data) data_we = ~we;
            end
            ack = is_data ? data_ack : fetch_ack;
        end while (!ack && lat < 50);
        rd = is_data ? data_rdata : fetch_rdata;
        fetch_req = 1'b0;
        data_req  = 1'b0;
        if (we) exp = wdata;
        else if (is_io) exp = 16'h8000;
        else exp = ref_read(addr);
        check({tag, " ack_latency"}, 32'(lat), 32'(L + 1));
        check({tag, " mem_en_cycles"}, 32'(en_n), is_io ? 32'd0 : 32'(L));
        check({tag, " mem_we_cycles"}, 32'(we_n), (we && !is_io) ? 32'(L) : 32'd0);
        check({tag, " io_en_cycles"}, 32'(io_n), is_io ? 32'(L) : 32'd0);
        check({tag, " addr_wdata_stable"}, 32'(stable), 32'd1);
        check({tag, " no_other_ack"}, 32'(other_ack), 32'd0);
        check({tag, " rdata"}, 32'(rd), 32'(exp));
        if (we) ref_mem[addr] = wdata;
        $display("txn %-12s %s %s addr=%h wdata=%h rdata=%h latency=%0d", tag,
                 is_data ? "data " : "fetch", we ? "W" : "R", addr, wdata, rd, lat);
    endtask

    initial begin
        int acks_seen, lat_cnt, last_ack;
        bit order [4];
        int when [4];
        logic [15:0] rdv [4];

        aclr = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h3000;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;

        // Reset state, with a fetch request already pending
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mem_en", 32'(mem_en), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset acks", {30'd0, fetch_ack, data_ack}, 32'd0);
        check("reset mar_mdr", {mem_addr, mem_wdata}, 32'd0);
        aclr = 1'b1;
        do_access(1'b0, 1'b0, 16'h3000, 16'h0000, "fetch_3000");

        // Store then load back
        do_access(1'b1, 1'b1, 16'h4000, 16'hBEEF, "store_4000");
        do_access(1'b1, 1'b0, 16'h4000, 16'h0000, "load_4000");

        // Both requesters held high: grants alternate starting from fetch after reset
        @(negedge clk); aclr = 1'b0;
        @(negedge clk); aclr = 1'b1;
        fetch_req = 1'b1; fetch_addr = 16'h3000;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h4000;
        acks_seen = 0; lat_cnt = 0;
        while (acks_seen < 4 && lat_cnt < 60) begin
            @(negedge clk);
            lat_cnt++;
            if (fetch_ack || data_ack) begin
                order[acks_seen] = data_ack;
                when[acks_seen]  = lat_cnt;
                rdv[acks_seen]   = data_ack ? data_rdata : fetch_rdata;
                acks_seen++;
            end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        check("rr ack_count", 32'(acks_seen), 32'd4);
        last_ack = 0;
        for (int i = 0; i < acks_seen; i++) begin
            check($sformatf("rr order%0d", i), 32'(order[i]), 32'(i % 2));
            check($sformatf("rr spacing%0d", i), 32'(when[i] - last_ack), (i == 0) ? 32'(L + 1) : 32'(L + 2));
            check($sformatf("rr rdata%0d", i), 32'(rdv[i]), (i % 2) ? 32'(ref_read(16'h4000)) : 32'(ref_read(16'h3000)));
            $display("txn rr_ack%0d %s cycle=%0d rdata=%h", i, order[i] ? "data " : "fetch", when[i], rdv[i]);
            last_ack = when[i];
        end

        // Reset during a store: enables drop at once, no ack, then the request is retried
        @(negedge clk);
        while (busy) @(negedge clk);
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h5000; data_wdata = 16'hCAFE;
        @(negedge clk);
        check("abort in_access", {30'd0, mem_en, mem_we}, 32'd3);
        #2 aclr = 1'b0;
        #1;
        check("abort mem_en", 32'(mem_en), 32'd0);
        check("abort mem_we", 32'(mem_we), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("abort no_ack", {30'd0, fetch_ack, data_ack}, 32'd0);
        aclr = 1'b1;
        do_access(1'b1, 1'b1, 16'h5000, 16'hCAFE, "store_5000");
        do_access(1'b1, 1'b0, 16'h5000, 16'h0000, "load_5000");

`ifdef LC3_MMIO_EN
        do_access(1'b1, 1'b0, 16'hFE02, 16'h0000, "io_load_FE02");
`endif

        // Random fetch/load/store traffic over a small address window
        for (int i = 0; i < 24; i++) begin
            int kind;
            logic [15:0] a, w;
            kind = int'($urandom_range(0, 2));
            a = 16'h6000 + 16'($urandom_range(0, 7));
            w = 16'($urandom);
            do_access(kind != 0, kind == 2, a, w, $sformatf("rand%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
